// File: rtl/apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb_master_arbiter
//
// Purpose:
//   Round-robin APB master. It shares one APB slave port among NumReq local
//   requesters. Each accepted request runs one SETUP phase and then one or more
//   ACCESS phases; slave wait states are honoured. The read data and error
//   status return to the requester that was granted.
//
// Optional feature (compile-time macro):
//   APB_MASTER_TIMEOUT_EN - bounds the ACCESS phase to TimeoutCycles cycles.
//                           On expiry the transfer completes with rsp_err=1 and
//                           rsp_rdata=0. Without the macro there is no counter
//                           and ACCESS waits for p_ready indefinitely.
//
// Parameters:
//   NumReq        - number of requesters (>= 2)
//   AddrBits      - APB address width
//   TimeoutCycles - ACCESS-phase wait limit (used only with the macro)
//
// Ports:
//   p_clk, p_resetn         clock, asynchronous active-low reset
//   req_valid/req_write     per-requester request and direction (1 = write)
//   req_addr/wdata/strb     packed payloads; requester i in slice i
//   req_ready               one-hot accept (combinational, IDLE only)
//   rsp_valid               one-hot, one-cycle completion pulse
//   rsp_rdata, rsp_err      completion data/status, valid with rsp_valid
//   p_addr ... p_strb       APB request outputs (registered)
//   p_rdata/p_ready/p_slverr APB response inputs
//   dbg_state               current FSM state (0 IDLE, 1 SETUP, 2 ACCESS)
//
// Handshake: a request transfers on a clock edge where req_valid[i] and
// req_ready[i] are both high. The requester holds req_valid and its payload
// stable until that edge. rsp_valid[i] is a pulse and has no back-pressure.
// -----------------------------------------------------------------------------
module apb_master_arbiter #(
  parameter int NumReq        = 2,
  parameter int AddrBits      = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                       p_clk,
  input  logic                       p_resetn,
  input  logic [NumReq-1:0]          req_valid,
  input  logic [NumReq-1:0]          req_write,
  input  logic [NumReq*AddrBits-1:0] req_addr,
  input  logic [NumReq*32-1:0]       req_wdata,
  input  logic [NumReq*4-1:0]        req_strb,
  output logic [NumReq-1:0]          req_ready,
  output logic [NumReq-1:0]          rsp_valid,
  output logic [31:0]                rsp_rdata,
  output logic                       rsp_err,
  output logic [AddrBits-1:0]        p_addr,
  output logic                       p_sel,
  output logic                       p_enable,
  output logic                       p_write,
  output logic [31:0]                p_wdata,
  output logic [3:0]                 p_strb,
  input  logic [31:0]                p_rdata,
  input  logic                       p_ready,
  input  logic                       p_slverr,
  output logic [1:0]                 dbg_state
);

  localparam int IdxBits = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t             state;
  logic [IdxBits-1:0] rr_ptr;
  logic [IdxBits-1:0] cur_idx;
  logic [IdxBits-1:0] grant_idx;
  logic [IdxBits-1:0] next_ptr;
  logic [IdxBits:0]   cand;
  logic               grant_any;
  logic               xfer_done;
  logic               done_err;
  logic [31:0]        done_rdata;

  // An elaboration-time guard on the parameters that the logic depends on.
  if (NumReq < 2 || TimeoutCycles < 1) begin : g_param_check
    $error("apb_master_arbiter: NumReq must be >= 2 and TimeoutCycles >= 1");
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CntBits = $clog2(TimeoutCycles + 1);
  logic [CntBits-1:0] wait_cnt;
`endif

  assign dbg_state = state;

  // The search starts at rr_ptr and wraps. The requester that was just served
  // moves to the back of the order, so a requester that keeps its request
  // asserted is never starved.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand = {1'b0, rr_ptr} + (IdxBits+1)'(k);
      if (cand >= (IdxBits+1)'(NumReq)) begin
        cand = cand - (IdxBits+1)'(NumReq);
      end
      if (!grant_any && req_valid[cand[IdxBits-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[IdxBits-1:0];
      end
    end
  end

  always_comb begin
    if (grant_idx == IdxBits'(NumReq - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = grant_idx + 1'b1;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Completion condition for the current ACCESS cycle. p_ready wins over an
  // expiring timeout in the same cycle.
  always_comb begin
    xfer_done  = 1'b0;
    done_err   = 1'b0;
    done_rdata = '0;
    if (state == ACCESS) begin
      if (p_ready) begin
        xfer_done  = 1'b1;
        done_err   = p_slverr;
        done_rdata = p_write ? 32'd0 : p_rdata;
      end
`ifdef APB_MASTER_TIMEOUT_EN
      else if (wait_cnt == CntBits'(TimeoutCycles - 1)) begin
        xfer_done = 1'b1;
        done_err  = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_idx   <= '0;
      p_addr    <= '0;
      p_sel     <= 1'b0;
      p_enable  <= 1'b0;
      p_write   <= 1'b0;
      p_wdata   <= '0;
      p_strb    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            cur_idx  <= grant_idx;
            rr_ptr   <= next_ptr;
            p_addr   <= req_addr[grant_idx*AddrBits +: AddrBits];
            p_write  <= req_write[grant_idx];
            // Reads drive zero data and strobes; writes forward the strobes as given.
            p_wdata  <= req_write[grant_idx] ? req_wdata[grant_idx*32 +: 32] : 32'd0;
            p_strb   <= req_write[grant_idx] ? req_strb[grant_idx*4 +: 4] : 4'd0;
            p_sel    <= 1'b1;
            p_enable <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          p_enable <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state    <= ACCESS;
        end
        ACCESS: begin
          if (xfer_done) begin
            rsp_valid[cur_idx] <= 1'b1;
            rsp_rdata          <= done_rdata;
            rsp_err            <= done_err;
            // Returning to IDLE parks every APB output at zero.
            p_sel    <= 1'b0;
            p_enable <= 1'b0;
            p_addr   <= '0;
            p_write  <= 1'b0;
            p_wdata  <= '0;
            p_strb   <= '0;
            state    <= IDLE;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Round-robin APB master that shares one APB slave port among `NumReq` local requesters. It arbitrates simple valid/ready requests and sequences APB SETUP/ACCESS phases, including slave wait states such as the multi-cycle byte-serial accesses of `APB_slave_8bit`. It returns read data and error status to the granted requester. It sits between core-side requesters and the APB slave's `p_*` port.

## Interface
- `NumReq`, 2: number of requesters, ≥2.
- `AddrBits`, 32: APB address width.
- `TimeoutCycles`, 16: ACCESS-phase wait limit. Used only with `APB_MASTER_TIMEOUT_EN`.

Ports:
- `p_clk` in 1: single clock.
- `p_resetn` in 1: asynchronous, active-low reset.
- `req_valid` in `NumReq`: request pending, one bit per requester.
- `req_write` in `NumReq`: 1 = write.
- `req_addr` in `NumReq*AddrBits`: packed addresses; requester i at `[i*AddrBits +: AddrBits]`.
- `req_wdata` in `NumReq*32`: packed write data.
- `req_strb` in `NumReq*4`: packed write strobes.
- `req_ready` out `NumReq`: one-hot request accept.
- `rsp_valid` out `NumReq`: one-hot, one-cycle completion pulse.
- `rsp_rdata` out 32: read data, valid with `rsp_valid`.
- `rsp_err` out 1: slave error or timeout, valid with `rsp_valid`.
- `p_addr` out `AddrBits`; `p_sel` out 1; `p_enable` out 1; `p_write` out 1; `p_wdata` out 32; `p_strb` out 4: APB request.
- `p_rdata` in 32; `p_ready` in 1; `p_slverr` in 1: APB response.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE
  - If any `req_valid` is set, grant the first set bit at or after `rr_ptr`, searching upward with wrap.
  - `req_ready[g]` is asserted combinationally in that cycle.
  - On the clock edge: latch addr, write, wdata, and strb into internal registers; set `rr_ptr = (g+1) mod NumReq`; go to SETUP.
  - With no request, stay in IDLE.
- SETUP: `p_sel=1`, `p_enable=0`, APB outputs taken from the latched registers. Next state is always ACCESS.
- ACCESS: `p_sel=1`, `p_enable=1`, APB outputs held stable.
  - On `p_ready=1`: register `rsp_rdata = p_write ? 0 : p_rdata` and `rsp_err = p_slverr`; pulse `rsp_valid[g]` next cycle; go to IDLE.
  - Otherwise stay in ACCESS (wait state).
- On reads, `p_strb` and `p_wdata` are driven to 0.
- On writes, `req_strb` is forwarded unchanged, including 0000.
- `p_slverr` and `p_rdata` are sampled only when `p_sel & p_enable & p_ready` are all high.
- While not in IDLE, all `req_ready` bits are 0. Requesters must hold `req_valid` and payload until `req_ready`.
- In IDLE, `p_sel=0`, `p_enable=0`, and `p_addr`, `p_write`, `p_wdata`, `p_strb` are all 0.

## Timing
- Reset values: state=IDLE, `rr_ptr=0`, every APB output 0, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, and `req_ready=0` unless `req_valid` is set.
- Latency: with the handshake in cycle T, SETUP is in T+1 and ACCESS in T+2. With W wait states, `rsp_valid` is high in cycle T+3+W.
- Throughput: there is always one IDLE cycle between transfers, giving at most one transfer per 3 cycles.
- Simultaneous requests: exactly one is granted. Losers keep `req_valid` and win in later rounds by rotation.
- Reset mid-transfer: `p_sel` and `p_enable` drop immediately. The in-flight transfer is discarded and no `rsp_valid` is produced.
- Errors complete the transfer normally, only with `rsp_err=1`.

## Configuration
- Macro `APB_MASTER_TIMEOUT_EN`.
- When defined:
  - An ACCESS-phase counter clears on entry to ACCESS and increments each cycle without `p_ready`.
  - When it reaches `TimeoutCycles`, the transfer terminates: `p_sel` and `p_enable` drop on the next edge; `rsp_valid[g]` pulses with `rsp_err=1` and `rsp_rdata=0`; state returns to IDLE.
  - `p_ready` arriving in the same cycle as the limit takes priority and gives a normal completion.
- When not defined: no counter exists, ACCESS waits indefinitely, and `TimeoutCycles` is unused.

## Test plan
- Single write, requester 0: addr=0x04, wdata=0xA5A5A5A5, strb=0001, slave ready on first ACCESS -> SETUP at T+1, ACCESS at T+2, `rsp_valid[0]` at T+3, `rsp_err=0`.
- Read with 3 wait states: slave returns 0x000000C3 -> `rsp_rdata=0x000000C3` at T+6, `p_addr` stable throughout.
- Both requesters valid continuously after reset -> grants in order 0,1,0,1. Each `req_ready` pulse is one-hot; no starvation.
- Slave asserts `p_slverr` with `p_ready` -> `rsp_err=1` and FSM back in IDLE. The next queued request proceeds normally.
- `p_resetn` low during ACCESS -> `p_sel=0` the same cycle, no `rsp_valid` pulse, next grant goes to requester 0.
- With `APB_MASTER_TIMEOUT_EN` and `TimeoutCycles=16`, `p_ready` held 0 -> after 16 ACCESS cycles, `rsp_valid` with `rsp_err=1` and `rsp_rdata=0`. Without the macro, `p_sel` stays high indefinitely.
